conv_weight_buffer: RTL

Parametrised local weight store for one convolution layer of the accelerator. Weights stream in one word per cycle as address-auto-incrementing bursts from the layer loader. The buffer serves two LANES-wide weight vectors per read request to the PE array: one at the vector base, one at a fixed filter-pair offset. It adds a sweep-clear mode, burst-length tracking with a done pulse, registered reads with a valid flag, and out-of-range detection.

---
 rtl/conv_weight_buffer_if.sv | 47 ++++
 rtl/conv_weight_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/conv_weight_buffer_if.sv
// conv_weight_buffer_if
// Bundles the loader, PE-array read and status signals of conv_weight_buffer.
//   master : the layer loader / PE array side. It drives the start, write and
//            read-request signals and receives the read data and status.
//   slave  : the weight buffer itself.
// Signals:
//   clear_start, wr_start, wr_base, wr_len     - burst / clear control
//   write_weight_signal, write_weight_data     - burst word stream
//   read_weight_signal, read_weight_addr       - vector read request
//   read_weight_data1/2, read_valid, read_oob  - registered read response
//   busy, load_done                            - status
interface conv_weight_buffer_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int ADDR_W = 16
);
    logic                      clear_start;
    logic                      wr_start;
    logic [ADDR_W-1:0]         wr_base;
    logic [ADDR_W-1:0]         wr_len;
    logic                      write_weight_signal;
    logic [DATA_W-1:0]         write_weight_data;
    logic                      read_weight_signal;
    logic [ADDR_W-1:0]         read_weight_addr;
    logic [LANES*DATA_W-1:0]   read_weight_data1;
    logic [LANES*DATA_W-1:0]   read_weight_data2;
    logic                      read_valid;
    logic                      read_oob;
    logic                      busy;
    logic                      load_done;

    modport master (
        output clear_start, wr_start, wr_base, wr_len,
        output write_weight_signal, write_weight_data,
        output read_weight_signal, read_weight_addr,
        input  read_weight_data1, read_weight_data2, read_valid, read_oob,
        input  busy, load_done
    );

    modport slave (
        input  clear_start, wr_start, wr_base, wr_len,
        input  write_weight_signal, write_weight_data,
        input  read_weight_signal, read_weight_addr,
        output read_weight_data1, read_weight_data2, read_valid, read_oob,
        output busy, load_done
    );
endinterface

// File: rtl/conv_weight_buffer.sv
// conv_weight_buffer
// Local weight store for one convolution layer. Weights arrive as
// address-auto-incrementing bursts, one word per strobe. Each read request
// returns two LANES-wide vectors: one at word addr*LANES and one PAIR_OFFSET
// words further on. A sweep-clear mode zeroes the whole store, LANES words
// per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - conv_weight_buffer_if.slave (control, write stream, reads, status)
module conv_weight_buffer #(
    parameter int DATA_W      = 16,
    parameter int LANES       = 8,
    parameter int DEPTH       = 2048,
    parameter int PAIR_OFFSET = 25,
    parameter int ADDR_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_weight_buffer_if.slave  bus
);
    localparam int LANE_W = $clog2(LANES);
    // Wide enough that addr*LANES + PAIR_OFFSET + LANES-1 never wraps.
    localparam int RA_W   = ADDR_W + LANE_W + 1;
    localparam int MA_W   = $clog2(DEPTH);
    // One spare bit so a burst starting near the top of the address range
    // keeps counting upward (and stays out of range) instead of wrapping.
    localparam int PTR_W  = ADDR_W + 1;
    localparam int VEC_W  = LANES * DATA_W;
    localparam logic [MA_W-1:0] LAST_SWEEP = MA_W'(DEPTH - LANES);

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic [MA_W-1:0]    sweep_q, sweep_d;
    logic               done_q, done_d;

    logic [VEC_W-1:0]   data1_q, data2_q;
    logic               valid_q, oob_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               wr_en;
    logic               rd_accept;
    logic [RA_W-1:0]    rd_base;
    logic [VEC_W-1:0]   vec1, vec2;
    logic [LANES-1:0]   oob1, oob2;

    // ------------------------------------------------------------------
    // Control FSM, next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sweep_d = sweep_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end else if (bus.wr_start) begin
                    ptr_d = {1'b0, bus.wr_base};
                    cnt_d = '0;
                    len_d = bus.wr_len;
                    // An empty burst is complete as soon as it is accepted,
                    // so it pulses load_done without ever leaving IDLE.
                    if (bus.wr_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.write_weight_signal) begin
                    ptr_d = ptr_q + PTR_W'(1);
                    cnt_d = cnt_q + ADDR_W'(1);
                    // Out-of-range words still count toward the burst length.
                    if (cnt_d == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                sweep_d = sweep_q + MA_W'(LANES);
                if (sweep_q == LAST_SWEEP) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sweep_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sweep_q <= sweep_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage. No reset: contents are defined only after a clear or load.
    // ------------------------------------------------------------------
    assign wr_en = (state_q == LOAD) && bus.write_weight_signal &&
                   (ptr_q < PTR_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            // Sweep pointer is LANES-aligned and DEPTH is a multiple of
            // LANES, so the beat never runs past the end of the array.
            for (int l = 0; l < LANES; l++) begin
                mem[sweep_q + MA_W'(l)] <= '0;
            end
        end else if (wr_en) begin
            mem[ptr_q[MA_W-1:0]] <= bus.write_weight_data;
        end
    end

    // ------------------------------------------------------------------
    // Read path: per-lane address, range check and word select. The memory
    // is sampled before this edge's write lands, giving read-before-write.
    // ------------------------------------------------------------------
    assign rd_accept = bus.read_weight_signal && (state_q != CLEAR);
    assign rd_base   = RA_W'(bus.read_weight_addr) * RA_W'(LANES);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [RA_W-1:0] addr1, addr2;
        assign addr1    = rd_base + RA_W'(gi);
        assign addr2    = rd_base + RA_W'(PAIR_OFFSET + gi);
        assign oob1[gi] = addr1 >= RA_W'(DEPTH);
        assign oob2[gi] = addr2 >= RA_W'(DEPTH);
        assign vec1[gi*DATA_W +: DATA_W] = oob1[gi] ? '0 : mem[addr1[MA_W-1:0]];
        assign vec2[gi*DATA_W +: DATA_W] = oob2[gi] ? '0 : mem[addr2[MA_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data1_q <= '0;
            data2_q <= '0;
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            valid_q <= rd_accept;
            // read_oob qualifies the response it belongs to.
            oob_q   <= rd_accept && ((|oob1) || (|oob2));
            if (rd_accept) begin
                data1_q <= vec1;
                data2_q <= vec2;
            end
        end
    end

    assign bus.read_weight_data1 = data1_q;
    assign bus.read_weight_data2 = data2_q;
    assign bus.read_valid        = valid_q;
    assign bus.read_oob          = oob_q;
    assign bus.busy              = (state_q != IDLE);
    assign bus.load_done         = done_q;
endmodule
